pio_debug_responder: RTL and testbench

Target-side endpoint of the Nios PIO debug channel. Decodes the address, control and 64-bit write-data words that the Nios drives onto its PIO outputs, executes the command against the RISC-V core's memory port and halt/step/reset controls, and returns read data and status flags on the Nios PIO inputs. It sits in the top level between the `coprocessor` Qsys system and the RISC-V core, in the same clock domain as both.

---
 rtl/pio_debug_responder_if.sv | 30 +++
 rtl/pio_debug_responder.sv | 136 +++++++++++++
 tb/tb_pio_debug_responder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_debug_responder_if.sv
// Nios PIO word/control bundle plus the core memory port seen by the debug responder.
// slave = responder side; master = Nios PIOs and memory port driving it.
interface pio_debug_responder_if;
  logic [14:0] pio_addr;
  logic [5:0]  pio_control;
  logic [31:0] pio_wdata_high;
  logic [31:0] pio_wdata_low;
  logic [31:0] pio_rdata_high;
  logic [31:0] pio_rdata_low;
  logic [1:0]  pio_flags;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  modport slave (
    input  pio_addr, pio_control, pio_wdata_high, pio_wdata_low, mem_ready, mem_rdata,
    output pio_rdata_high, pio_rdata_low, pio_flags,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output pio_addr, pio_control, pio_wdata_high, pio_wdata_low, mem_ready, mem_rdata,
    input  pio_rdata_high, pio_rdata_low, pio_flags,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/pio_debug_responder.sv
// Target-side endpoint of the Nios PIO debug channel: four-phase req/done handshake
// driving the core memory port and halt/step/reset controls. All outputs registered.
module pio_debug_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  pio_debug_responder_if.slave        bus,
  output logic                        cpu_halt,
  output logic                        cpu_step,
  output logic                        cpu_reset,
  input  logic                        cpu_halted
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STEP, S_DONE} state_t;

  localparam logic [2:0]  OP_NOP    = 3'd0;
  localparam logic [2:0]  OP_READ   = 3'd1;
  localparam logic [2:0]  OP_WRITE  = 3'd2;
  localparam logic [2:0]  OP_WLOW   = 3'd3;
  localparam logic [2:0]  OP_STEP   = 3'd4;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req, req_q, req_rise;
  logic [2:0]  op_q, op_d;
  logic [15:0] wait_q, wait_d;
  logic        done_q, done_d, err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic        mreq_q, mreq_d, we_q, we_d, step_d;
  logic [14:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;

  assign req      = bus.pio_control[0];
  assign req_rise = req & ~req_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mreq_d  = mreq_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: if (req_rise) begin
        op_d    = bus.pio_control[3:1];
        addr_d  = bus.pio_addr;
        wdata_d = {bus.pio_wdata_high, bus.pio_wdata_low};
        wait_d  = '0;
        case (bus.pio_control[3:1])
          OP_READ:  begin state_d = S_ISSUE; mreq_d = 1'b1; we_d = 1'b0; be_d = 8'hFF; end
          OP_WRITE: begin state_d = S_ISSUE; mreq_d = 1'b1; we_d = 1'b1; be_d = 8'hFF; end
          OP_WLOW:  begin state_d = S_ISSUE; mreq_d = 1'b1; we_d = 1'b1; be_d = 8'h0F; end
          OP_STEP: begin
            if (cpu_halted) begin
              state_d = S_STEP;
              step_d  = 1'b1;
            end else begin
              state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
            end
          end
          OP_NOP:  begin state_d = S_DONE; done_d = 1'b1; err_d = 1'b0; end
          default: begin state_d = S_DONE; done_d = 1'b1; err_d = 1'b1; end
        endcase
      end
      // mem_ready wins over the timeout when both land on the last wait cycle
      S_ISSUE: begin
        if (bus.mem_ready) begin
          mreq_d = 1'b0;
          if (op_q == OP_READ) rdata_d = bus.mem_rdata;
          state_d = S_DONE; done_d = 1'b1; err_d = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          mreq_d  = 1'b0;
          state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_STEP: begin state_d = S_DONE; done_d = 1'b1; err_d = 1'b0; end
      S_DONE: if (!req) begin state_d = S_IDLE; done_d = 1'b0; end
      default: state_d = S_IDLE;
    endcase
  end

  // req_q resets high so a req already asserted at reset release is not a new command
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b1;
      op_q      <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mreq_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cpu_step  <= 1'b0;
      cpu_halt  <= 1'b0;
      cpu_reset <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      op_q      <= op_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      mreq_q    <= mreq_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cpu_step  <= step_d;
      cpu_halt  <= bus.pio_control[4];
      cpu_reset <= bus.pio_control[5];
    end
  end

  assign bus.pio_flags      = {err_q, done_q};
  assign bus.pio_rdata_high = rdata_q[63:32];
  assign bus.pio_rdata_low  = rdata_q[31:0];
  assign bus.mem_req        = mreq_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_be         = be_q;
endmodule

// File: tb/tb_pio_debug_responder.sv
// Bench for pio_debug_responder: expected flags/rdata queued at command issue and
// popped when done is observed; memory port modelled inline per command.
module tb_pio_debug_responder;
  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic cpu_halt, cpu_step, cpu_reset, cpu_halted;

  pio_debug_responder_if bus();

  pio_debug_responder #(.TIMEOUT_CYCLES(4)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .bus(bus),
    .cpu_halt(cpu_halt), .cpu_step(cpu_step), .cpu_reset(cpu_reset), .cpu_halted(cpu_halted)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct { logic [1:0] flags; logic [63:0] rdata; } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_bad = 0;
  logic        halt_bit = 1'b0;
  logic [63:0] model_rd = 64'h0;

  logic [1:0]  r_fl, r_fl_after;
  logic [63:0] r_rd, r_wd;
  logic [14:0] r_ma;
  logic        r_we;
  logic [7:0]  r_be;
  int          r_lat, r_req_cyc, r_step_cyc;

  // Raise req with the given command, answer mem_req after ready_after cycles
  // (negative = never), wait (bounded) for done, then drop req and sample once more.
  task automatic do_cmd(input logic [2:0] op, input logic [14:0] addr, input logic [63:0] wd,
                        input int ready_after, input logic [63:0] rd);
    bit got = 0;
    r_lat = -1; r_req_cyc = 0; r_step_cyc = 0;
    r_fl = 'x; r_rd = 'x; r_ma = 'x; r_we = 'x; r_be = 'x; r_wd = 'x;
    bus.pio_addr = addr;
    bus.pio_wdata_high = wd[63:32];
    bus.pio_wdata_low  = wd[31:0];
    bus.pio_control = {1'b0, halt_bit, op, 1'b1};
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk_clk);
      bus.mem_ready = 1'b0;
      if (bus.pio_flags[0]) begin
        got = 1; r_lat = cyc; r_fl = bus.pio_flags;
        r_rd = {bus.pio_rdata_high, bus.pio_rdata_low};
      end else begin
        if (cpu_step) r_step_cyc++;
        if (bus.mem_req) begin
          r_req_cyc++;
          r_ma = bus.mem_addr; r_we = bus.mem_we; r_be = bus.mem_be; r_wd = bus.mem_wdata;
          if (ready_after >= 0 && r_req_cyc == ready_after + 1) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = rd;
          end
        end
      end
    end
    bus.mem_ready = 1'b0;
    bus.pio_control[0] = 1'b0;
    @(negedge clk_clk);
    r_fl_after = bus.pio_flags;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.pio_control = 6'b000001;
    reset_reset_n = 1'b1;
    #2 reset_reset_n = 1'b0;
    repeat (2) @(negedge clk_clk);
    n_vec++;
    if (bus.pio_flags !== 2'b00 || {bus.pio_rdata_high, bus.pio_rdata_low} !== 64'h0) begin
      n_bad++; $display("FAIL reset_flags_rdata got %b/%h want 00/0", bus.pio_flags, {bus.pio_rdata_high, bus.pio_rdata_low});
    end
    n_vec++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 10'h0 || bus.mem_addr !== 15'h0 || bus.mem_wdata !== 64'h0) begin
      n_bad++; $display("FAIL reset_mem got req=%b we=%b be=%h addr=%h wd=%h want all 0", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    n_vec++;
    if ({cpu_halt, cpu_step, cpu_reset} !== 3'b000) begin
      n_bad++; $display("FAIL reset_cpu got %b want 000", {cpu_halt, cpu_step, cpu_reset});
    end
    reset_reset_n = 1'b1;
    repeat (4) @(negedge clk_clk);
    n_vec++;
    if (bus.pio_flags !== 2'b00 || bus.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL held_req_ignored got flags=%b mem_req=%b want 00/0", bus.pio_flags, bus.mem_req);
    end
    bus.pio_control = 6'b0;
    @(negedge clk_clk);
    sb.push_back('{flags: 2'b01, rdata: model_rd});
    do_cmd(3'd0, 15'h0, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_fl !== e.flags || r_lat !== 1) begin
      n_bad++; $display("FAIL nop_after_reset got flags=%b lat=%0d want %b/1", r_fl, r_lat, e.flags);
    end
  endtask

  task automatic test_read();
    exp_t e;
    sb.push_back('{flags: 2'b01, rdata: 64'hDEADBEEF_01234567});
    model_rd = 64'hDEADBEEF_01234567;
    do_cmd(3'd1, 15'h1234, 64'h0, 3, 64'hDEADBEEF_01234567);
    e = sb.pop_front();
    n_vec++;
    if (r_ma !== 15'h1234 || r_we !== 1'b0) begin
      n_bad++; $display("FAIL read_addr_we got %h/%b want 1234/0", r_ma, r_we);
    end
    n_vec++;
    if (r_fl !== e.flags || r_rd !== e.rdata) begin
      n_bad++; $display("FAIL read_data got %b/%h want %b/%h", r_fl, r_rd, e.flags, e.rdata);
    end
    n_vec++;
    if (r_lat !== 5 || r_fl_after !== 2'b00) begin
      n_bad++; $display("FAIL read_timing got lat=%0d after=%b want 5/00", r_lat, r_fl_after);
    end
  endtask

  task automatic test_write_low();
    exp_t e;
    sb.push_back('{flags: 2'b01, rdata: model_rd});
    do_cmd(3'd3, 15'h7FFF, 64'hAAAA5555_CAFEF00D, 1, 64'h1111_2222_3333_4444);
    e = sb.pop_front();
    n_vec++;
    if (r_we !== 1'b1 || r_be !== 8'h0F || r_wd !== 64'hAAAA5555_CAFEF00D || r_ma !== 15'h7FFF) begin
      n_bad++; $display("FAIL write_low_bus got we=%b be=%h wd=%h addr=%h want 1/0f/aaaa5555cafef00d/7fff", r_we, r_be, r_wd, r_ma);
    end
    n_vec++;
    if (r_fl !== e.flags || r_rd !== e.rdata) begin
      n_bad++; $display("FAIL write_low_flags_rdata got %b/%h want %b/%h", r_fl, r_rd, e.flags, e.rdata);
    end
  endtask

  task automatic test_write();
    exp_t e;
    sb.push_back('{flags: 2'b01, rdata: model_rd});
    do_cmd(3'd2, 15'h0001, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_we !== 1'b1 || r_be !== 8'hFF || r_wd !== 64'h0123_4567_89AB_CDEF) begin
      n_bad++; $display("FAIL write_bus got we=%b be=%h wd=%h want 1/ff/0123456789abcdef", r_we, r_be, r_wd);
    end
    n_vec++;
    if (r_fl !== e.flags || r_rd !== e.rdata || r_lat !== 2) begin
      n_bad++; $display("FAIL write_done got %b/%h lat=%0d want %b/%h/2", r_fl, r_rd, r_lat, e.flags, e.rdata);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{flags: 2'b11, rdata: model_rd});
    do_cmd(3'd1, 15'h0ABC, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_req_cyc !== 4) begin
      n_bad++; $display("FAIL timeout_req_cycles got %0d want 4", r_req_cyc);
    end
    n_vec++;
    if (r_fl !== e.flags || r_rd !== e.rdata || r_fl_after !== 2'b10) begin
      n_bad++; $display("FAIL timeout_flags got %b/%h after=%b want %b/%h/10", r_fl, r_rd, r_fl_after, e.flags, e.rdata);
    end
    sb.push_back('{flags: 2'b01, rdata: model_rd});
    do_cmd(3'd0, 15'h0, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_fl !== e.flags) begin
      n_bad++; $display("FAIL nop_clears_error got %b want %b", r_fl, e.flags);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    for (int op = 5; op <= 7; op++) begin
      sb.push_back('{flags: 2'b11, rdata: model_rd});
      do_cmd(3'(op), 15'h0010, 64'h0, 0, 64'h0);
      e = sb.pop_front();
      n_vec++;
      if (r_fl !== e.flags || r_lat !== 1 || r_req_cyc !== 0) begin
        n_bad++; $display("FAIL illegal_op%0d got flags=%b lat=%0d req=%0d want %b/1/0", op, r_fl, r_lat, r_req_cyc, e.flags);
      end
    end
  endtask

  task automatic test_early_drop();
    exp_t e;
    sb.push_back('{flags: 2'b01, rdata: 64'h0BAD_F00D_1357_2468});
    model_rd = 64'h0BAD_F00D_1357_2468;
    bus.pio_addr = 15'h0042;
    bus.pio_control = {1'b0, halt_bit, 3'd1, 1'b1};
    @(negedge clk_clk);
    bus.pio_control[0] = 1'b0;
    n_vec++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++; $display("FAIL early_drop_req got mem_req=%b want 1", bus.mem_req);
    end
    @(negedge clk_clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 64'h0BAD_F00D_1357_2468;
    @(negedge clk_clk);
    bus.mem_ready = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (bus.pio_flags !== e.flags || {bus.pio_rdata_high, bus.pio_rdata_low} !== e.rdata) begin
      n_bad++; $display("FAIL early_drop_done got %b/%h want %b/%h", bus.pio_flags, {bus.pio_rdata_high, bus.pio_rdata_low}, e.flags, e.rdata);
    end
    @(negedge clk_clk);
    n_vec++;
    if (bus.pio_flags !== 2'b00) begin
      n_bad++; $display("FAIL early_drop_pulse got %b want 00", bus.pio_flags);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [14:0] a;
    logic [63:0] d;
    int dly;
    for (int i = 0; i < 6; i++) begin
      a = 15'($urandom);
      d = {$urandom, $urandom};
      dly = $urandom_range(0, 3);
      sb.push_back('{flags: 2'b01, rdata: d});
      model_rd = d;
      do_cmd(3'd1, a, 64'h0, dly, d);
      e = sb.pop_front();
      n_vec++;
      if (r_fl !== e.flags || r_rd !== e.rdata || r_ma !== a || r_lat !== dly + 2) begin
        n_bad++; $display("FAIL b2b_read%0d got %b/%h addr=%h lat=%0d want %b/%h/%h/%0d", i, r_fl, r_rd, r_ma, r_lat, e.flags, e.rdata, a, dly + 2);
      end
    end
  endtask

  task automatic test_step();
    exp_t e;
    cpu_halted = 1'b0;
    sb.push_back('{flags: 2'b11, rdata: model_rd});
    do_cmd(3'd4, 15'h0, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_fl !== e.flags || r_step_cyc !== 0 || r_lat !== 1) begin
      n_bad++; $display("FAIL step_unhalted got flags=%b steps=%0d lat=%0d want %b/0/1", r_fl, r_step_cyc, r_lat, e.flags);
    end
    halt_bit = 1'b1;
    bus.pio_control = 6'b110000;
    @(negedge clk_clk);
    n_vec++;
    if (cpu_halt !== 1'b1 || cpu_reset !== 1'b1) begin
      n_bad++; $display("FAIL ctrl_copy got halt=%b reset=%b want 1/1", cpu_halt, cpu_reset);
    end
    bus.pio_control = 6'b010000;
    cpu_halted = 1'b1;
    @(negedge clk_clk);
    sb.push_back('{flags: 2'b01, rdata: model_rd});
    do_cmd(3'd4, 15'h0, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_fl !== e.flags || r_step_cyc !== 1 || r_lat !== 2 || cpu_reset !== 1'b0) begin
      n_bad++; $display("FAIL step_halted got flags=%b steps=%0d lat=%0d rst=%b want %b/1/2/0", r_fl, r_step_cyc, r_lat, cpu_reset, e.flags);
    end
    halt_bit = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    bus.pio_addr = 15'h0055;
    bus.pio_control = {1'b0, halt_bit, 3'd2, 1'b1};
    @(negedge clk_clk);
    n_vec++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++; $display("FAIL mid_write_req got %b want 1", bus.mem_req);
    end
    #2 reset_reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_req !== 1'b0 || bus.pio_flags !== 2'b00) begin
      n_bad++; $display("FAIL async_reset got mem_req=%b flags=%b want 0/00", bus.mem_req, bus.pio_flags);
    end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    model_rd = 64'h0;
    @(negedge clk_clk);
    n_vec++;
    if (bus.mem_req !== 1'b0 || bus.pio_flags !== 2'b00) begin
      n_bad++; $display("FAIL post_reset_idle got mem_req=%b flags=%b want 0/00", bus.mem_req, bus.pio_flags);
    end
    bus.pio_control[0] = 1'b0;
    @(negedge clk_clk);
    sb.push_back('{flags: 2'b11, rdata: model_rd});
    do_cmd(3'd7, 15'h0, 64'h0, -1, 64'h0);
    e = sb.pop_front();
    n_vec++;
    if (r_fl !== e.flags || r_rd !== e.rdata) begin
      n_bad++; $display("FAIL illegal_after_reset got %b/%h want %b/%h", r_fl, r_rd, e.flags, e.rdata);
    end
  endtask

  initial begin
    bus.pio_addr = '0; bus.pio_control = '0;
    bus.pio_wdata_high = '0; bus.pio_wdata_low = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    cpu_halted = 1'b0;
    test_reset();
    test_read();
    test_write_low();
    test_write();
    test_timeout();
    test_illegal();
    test_early_drop();
    test_back_to_back();
    test_step();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
